dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits in the MEM/WB stage of the RV32 pipeline and answers the core's data-memory requests: address, store data, byte write enables and load request.
- Asserts a miss/stall flag that the hazard unit uses to freeze the pipeline.
- On a miss it writes back any dirty victim line, then refills the line word-serially from main memory.

Parameters:
- LINE_ADDR_LEN, 3: log2 words per line (8 words).
- SET_ADDR_LEN, 4: log2 number of sets (16).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (23 with defaults).

Ports:
- clk, in, 1: core clock.
- rst, in, 1: synchronous, active-high reset.
- addr, in, 32: byte address from the core (AluOutM); bits [1:0] ignored.
- write_data, in, 32: store data, already lane-aligned by the core.
- write_en, in, 4: byte write enables; nonzero means store.
- read_req, in, 1: load request (MemToRegM).
- read_data, out, 32: registered load data word.
- miss, out, 1: combinational stall to the hazard unit (DCacheMiss).
- mem_req, out, 1: word transfer request to main memory.
- mem_we, out, 1: 1 = write-back word, 0 = refill word.
- mem_addr, out, 32: word-aligned main-memory address.
- mem_wdata, out, 32: write-back data.
- mem_rdata, in, 32: refill data, valid when mem_ack=1.
- mem_ack, in, 1: memory accepts/returns one word this cycle.
- hit_count, out, 32: accesses completed without a miss.
- miss_count, out, 32: misses detected.

Behaviour:
- Address split: tag = addr[31 -: TAG_ADDR_LEN], set = next SET_ADDR_LEN bits, word = next LINE_ADDR_LEN bits, then 2 byte-offset bits.
- Request: active when read_req=1 or write_en!=0. If both are set, the access is treated as a store (read_data is not updated).
- Hit: valid[set] && tag_array[set]==tag.
- miss = request && (state!=IDLE || !hit). Combinational. 0 when there is no request.
- Access acceptance: on a clock edge with a request and miss=0.
  - Store: merges the enabled bytes into the word and sets dirty[set].
  - Load: read_data <= word, visible from the following cycle (latency 1).
  - hit_count++ (wraps at 2^32).
- The core holds addr, write_data, write_en and read_req stable while miss=1.
- FSM state IDLE:
  - On a request that misses: miss_count++ (once per miss) and latch the victim tag.
  - Go to WB if valid && dirty, otherwise go to FILL.
  - word_cnt <= 0.
- FSM state WB:
  - mem_req=1, mem_we=1, mem_addr={victim_tag,set,word_cnt,2'b00}, mem_wdata=line[set][word_cnt].
  - Each cycle with mem_ack=1: word_cnt++.
  - When word_cnt==LINE_WORDS-1 and mem_ack=1: word_cnt<=0, go to FILL.
- FSM state FILL:
  - mem_req=1, mem_we=0, mem_addr={tag,set,word_cnt,2'b00}.
  - Each cycle with mem_ack=1: write mem_rdata into line[set][word_cnt], word_cnt++.
  - On the last word: set tag_array[set]<=tag, valid<=1, dirty<=0, go to IDLE.
  - The core request is then a hit on the next cycle (miss drops) and completes normally.
- Idle outputs: mem_req=0 in IDLE; mem_addr and mem_wdata are don't-care when mem_req=0.
- mem_ack low: the state, word_cnt and the array are unchanged. The transaction waits indefinitely.
- Line valid bit: stays 0 until the last refill word arrives. A partial line never hits.
- Reset (any state, including mid-WB or mid-FILL):
  - state=IDLE, word_cnt=0, all valid=0, all dirty=0.
  - read_data=0, hit_count=0, miss_count=0, mem_req=0 in the next cycle.
  - Data and tag arrays are not cleared.
  - A partially written-back victim is lost. This is acceptable because reset reinitialises the system.
- miss_count increments exactly once per miss event, never once per stalled cycle.

Decomposition:
- dcache_pkg holds:
  - State enum {IDLE, WB, FILL}.
  - Localparams LINE_WORDS=1<<LINE_ADDR_LEN, SETS=1<<SET_ADDR_LEN.
  - Address-field helper functions for tag, set and word extraction.
- One sub-module, dcache_line_store: data array of SETS x LINE_WORDS x 32 bits.
  - One write port with a 4-bit byte mask (used for store merge and refill).
  - One combinational read port for write-back data and hit data.
- The top level holds tag/valid/dirty, the FSM, the counters and the memory interface.

Test Plan:
- Cold load: read_req at 0x0000_0100, memory returns 0xA000_0000+index.
  - miss=1 immediately.
  - 8 FILL reads at 0x100..0x11C, no WB.
  - miss drops, read_data=0xA000_0000 next cycle.
  - miss_count=1, hit_count=1.
- Store hit with byte enables: after the cold load, write 0xDEADBEEF with write_en=4'b0110 at 0x104, then load 0x104.
  - read_data=0xA0ADBE01 (bytes 1 and 2 merged).
  - No memory traffic.
- Dirty eviction: after the store, load 0x0000_0300 (same set, different tag).
  - 8 WB writes at 0x100..0x11C, the word at 0x104 carrying 0xA0ADBE01.
  - Then 8 FILL reads at 0x300..0x31C.
  - miss_count increments by 1.
- Memory backpressure: hold mem_ack=0 for 5 cycles mid-FILL at word 3.
  - mem_addr stays at word 3, miss stays 1.
  - The fill resumes and completes with correct data.
- Reset mid-FILL: assert rst after 4 refill words.
  - Next cycle: mem_req=0, counters=0, read_data=0.
  - A repeat load of the same address misses and performs a full 8-word FILL.
- No request for 10 cycles: miss=0, mem_req=0, both counters unchanged.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the cache geometry, the controller state encoding and helpers
// that split a 32-bit byte address into tag, set and word fields.
// The geometry lives here so the controller and the data array always agree.
package dcache_pkg;

  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 4;
  localparam int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
  localparam int SETS          = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } dcacheState_e;

  function automatic logic [TAG_ADDR_LEN-1:0] addrTag(input logic [31:0] addr);
    return addr[31 -: TAG_ADDR_LEN];
  endfunction

  function automatic logic [SET_ADDR_LEN-1:0] addrSet(input logic [31:0] addr);
    return addr[31-TAG_ADDR_LEN -: SET_ADDR_LEN];
  endfunction

  function automatic logic [LINE_ADDR_LEN-1:0] addrWord(input logic [31:0] addr);
    return addr[2 +: LINE_ADDR_LEN];
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Data array of the cache: SETS lines of LINE_WORDS 32-bit words.
// Ports:
//   clk_i               - core clock
//   we_i, byteEn_i      - write strobe and per-byte lane mask
//   wrSet_i, wrWord_i   - word being written (store merge or refill)
//   wdata_i             - write data, lane aligned
//   rdSet_i, rdWord_i   - combinational read address
//   rdata_o             - word at the read address
// The array has no reset; contents are only meaningful under a valid tag.
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [3:0]               byteEn_i,
  input  logic [SET_ADDR_LEN-1:0]  wrSet_i,
  input  logic [LINE_ADDR_LEN-1:0] wrWord_i,
  input  logic [31:0]              wdata_i,
  input  logic [SET_ADDR_LEN-1:0]  rdSet_i,
  input  logic [LINE_ADDR_LEN-1:0] rdWord_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] dataArray_q [SETS*LINE_WORDS];

  // Byte-masked write so a partial store only touches its enabled lanes.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn_i[b]) begin
          dataArray_q[{wrSet_i, wrWord_i}][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = dataArray_q[{rdSet_i, rdWord_i}];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM/WB stage.
// Ports:
//   clk_i, rst_i          - core clock, synchronous active-high reset
//   addr_i                - core byte address (bits [1:0] ignored)
//   write_data_i          - lane-aligned store data
//   write_en_i            - byte enables, nonzero means store
//   read_req_i            - load request
//   read_data_o           - registered load data (one cycle after acceptance)
//   miss_o                - combinational stall to the hazard unit
//   mem_req_o, mem_we_o   - word transfer request, 1 = write-back, 0 = refill
//   mem_addr_o            - word-aligned memory address
//   mem_wdata_o           - write-back data
//   mem_rdata_i, mem_ack_i- refill data and per-word handshake
//   hit_count_o           - accesses completed without a miss
//   miss_count_o          - miss events detected
module dcache_responder
  import dcache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_en_i,
  input  logic        read_req_i,
  output logic [31:0] read_data_o,
  output logic        miss_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;

  dcacheState_e state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] wordCnt_q, wordCnt_d;
  logic [TAG_ADDR_LEN-1:0]  tagArray_q [SETS];
  logic [TAG_ADDR_LEN-1:0]  victimTag_q;
  logic [SETS-1:0]          valid_q, dirty_q;
  logic [31:0]              readData_q, hitCount_q, missCount_q;

  logic [TAG_ADDR_LEN-1:0]  reqTag;
  logic [SET_ADDR_LEN-1:0]  reqSet;
  logic [LINE_ADDR_LEN-1:0] reqWord;
  logic request, isStore, hit, accept, missEvent, fillDone;
  logic storeWe;
  logic [3:0] storeMask;
  logic [31:0] storeData, lineRdata;
  logic [LINE_ADDR_LEN-1:0] wrWord, rdWord;

  assign reqTag  = addrTag(addr_i);
  assign reqSet  = addrSet(addr_i);
  assign reqWord = addrWord(addr_i);

  // A store wins when both load and store are requested together.
  assign isStore = |write_en_i;
  assign request = read_req_i | isStore;
  assign hit     = valid_q[reqSet] && (tagArray_q[reqSet] == reqTag);
  assign miss_o  = request && ((state_q != IDLE) || !hit);
  assign accept  = request && !miss_o;

  dcache_line_store uLineStore (
    .clk_i    (clk_i),
    .we_i     (storeWe),
    .byteEn_i (storeMask),
    .wrSet_i  (reqSet),
    .wrWord_i (wrWord),
    .wdata_i  (storeData),
    .rdSet_i  (reqSet),
    .rdWord_i (rdWord),
    .rdata_o  (lineRdata)
  );

  // Next-state logic and memory interface. The victim line shares the set
  // of the current request, so only the tag half of the address changes
  // between write-back and refill.
  always_comb begin
    state_d     = state_q;
    wordCnt_d   = wordCnt_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    storeWe     = 1'b0;
    storeMask   = write_en_i;
    storeData   = write_data_i;
    wrWord      = reqWord;
    rdWord      = reqWord;
    missEvent   = 1'b0;
    fillDone    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && isStore) begin
          storeWe = 1'b1;
        end
        if (request && !hit) begin
          missEvent = 1'b1;
          wordCnt_d = '0;
          state_d   = (valid_q[reqSet] && dirty_q[reqSet]) ? WB : FILL;
        end
      end
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {victimTag_q, reqSet, wordCnt_q, 2'b00};
        rdWord      = wordCnt_q;
        mem_wdata_o = lineRdata;
        if (mem_ack_i) begin
          if (wordCnt_q == LAST_WORD) begin
            wordCnt_d = '0;
            state_d   = FILL;
          end else begin
            wordCnt_d = wordCnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {reqTag, reqSet, wordCnt_q, 2'b00};
        if (mem_ack_i) begin
          storeWe   = 1'b1;
          storeMask = 4'hF;
          storeData = mem_rdata_i;
          wrWord    = wordCnt_q;
          if (wordCnt_q == LAST_WORD) begin
            fillDone  = 1'b1;
            wordCnt_d = '0;
            state_d   = IDLE;
          end else begin
            wordCnt_d = wordCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line status bits, load data and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      readData_q  <= '0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      if (missEvent) begin
        missCount_q <= missCount_q + 32'd1;
      end
      if (accept) begin
        hitCount_q <= hitCount_q + 32'd1;
        if (isStore) begin
          dirty_q[reqSet] <= 1'b1;
        end else begin
          readData_q <= lineRdata;
        end
      end
      if (fillDone) begin
        valid_q[reqSet] <= 1'b1;
        dirty_q[reqSet] <= 1'b0;
      end
    end
  end

  // Tag storage is not reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk_i) begin
    if (missEvent) begin
      victimTag_q <= tagArray_q[reqSet];
    end
    if (fillDone) begin
      tagArray_q[reqSet] <= reqTag;
    end
  end

  assign read_data_o  = readData_q;
  assign hit_count_o  = hitCount_q;
  assign miss_count_o = missCount_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed testbench for dcache_responder. Inputs change and outputs are
// compared on the falling clock edge; the DUT acts on the rising edge.
module tb_dcache_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i, write_data_i, mem_rdata_i;
  logic [3:0]  write_en_i;
  logic        read_req_i, mem_ack_i;
  logic [31:0] read_data_o, mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o;
  logic        miss_o, mem_req_o, mem_we_o;

  int checks = 0;
  int errors = 0;

  dcache_responder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .write_en_i   (write_en_i),
    .read_req_i   (read_req_i),
    .read_data_o  (read_data_o),
    .miss_o       (miss_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] we, input logic rd);
    addr_i       = addr;
    write_data_i = wdata;
    write_en_i   = we;
    read_req_i   = rd;
  endtask

  // Serves refill words base+4i with data dataBase+i; optionally withholds
  // mem_ack for 5 cycles before word stallWord.
  task automatic runFill(input logic [31:0] base, input logic [31:0] dataBase,
                         input int stallWord, input int words);
    for (int i = 0; i < words; i++) begin
      if (i == stallWord) begin
        mem_ack_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          checkOutput("stall_addr", mem_addr_o, base + 32'(4*i));
          checkOutput("stall_miss", {31'd0, miss_o}, 32'd1);
          nextCycle();
        end
      end
      checkOutput("fill_req", {31'd0, mem_req_o}, 32'd1);
      checkOutput("fill_we", {31'd0, mem_we_o}, 32'd0);
      checkOutput("fill_addr", mem_addr_o, base + 32'(4*i));
      checkOutput("fill_miss", {31'd0, miss_o}, 32'd1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = dataBase + 32'(i);
      nextCycle();
    end
    mem_ack_i = 1'b0;
  endtask

  // Accepts eight write-back words; word patchIdx carries patchVal.
  task automatic runWb(input logic [31:0] base, input logic [31:0] dataBase,
                       input int patchIdx, input logic [31:0] patchVal);
    for (int i = 0; i < 8; i++) begin
      checkOutput("wb_req", {31'd0, mem_req_o}, 32'd1);
      checkOutput("wb_we", {31'd0, mem_we_o}, 32'd1);
      checkOutput("wb_addr", mem_addr_o, base + 32'(4*i));
      checkOutput("wb_data", mem_wdata_o, (i == patchIdx) ? patchVal : dataBase + 32'(i));
      mem_ack_i = 1'b1;
      nextCycle();
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b0);
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
    checkOutput("rst_read_data", read_data_o, 32'h0);
    checkOutput("rst_hit_count", hit_count_o, 32'd0);
    checkOutput("rst_miss_count", miss_count_o, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_miss", {31'd0, miss_o}, 32'd0);

    $display("[TB] cold load 0x100");
    applyStimulus(32'h0000_0100, 32'h0, 4'h0, 1'b1);
    #1 checkOutput("cold_miss_comb", {31'd0, miss_o}, 32'd1);
    nextCycle();
    checkOutput("cold_miss_count", miss_count_o, 32'd1);
    runFill(32'h0000_0100, 32'hA000_0000, -1, 8);
    checkOutput("cold_hit_miss", {31'd0, miss_o}, 32'd0);
    checkOutput("cold_idle_req", {31'd0, mem_req_o}, 32'd0);
    nextCycle();
    checkOutput("cold_read_data", read_data_o, 32'hA000_0000);
    checkOutput("cold_hit_count", hit_count_o, 32'd1);
    checkOutput("cold_miss_count2", miss_count_o, 32'd1);

    $display("[TB] store hit with byte enables");
    applyStimulus(32'h0000_0104, 32'hDEAD_BEEF, 4'b0110, 1'b0);
    #1 checkOutput("store_miss", {31'd0, miss_o}, 32'd0);
    nextCycle();
    checkOutput("store_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("store_hit_count", hit_count_o, 32'd2);
    applyStimulus(32'h0000_0104, 32'h0, 4'h0, 1'b1);
    #1 checkOutput("reload_miss", {31'd0, miss_o}, 32'd0);
    nextCycle();
    checkOutput("merge_read_data", read_data_o, 32'hA0AD_BE01);
    checkOutput("merge_hit_count", hit_count_o, 32'd3);
    checkOutput("merge_mem_req", {31'd0, mem_req_o}, 32'd0);

    $display("[TB] dirty eviction with backpressure");
    applyStimulus(32'h0000_0300, 32'h0, 4'h0, 1'b1);
    #1 checkOutput("evict_miss", {31'd0, miss_o}, 32'd1);
    nextCycle();
    checkOutput("evict_miss_count", miss_count_o, 32'd2);
    runWb(32'h0000_0100, 32'hA000_0000, 1, 32'hA0AD_BE01);
    runFill(32'h0000_0300, 32'hB000_0000, 3, 8);
    checkOutput("evict_hit_miss", {31'd0, miss_o}, 32'd0);
    nextCycle();
    checkOutput("evict_read_data", read_data_o, 32'hB000_0000);
    checkOutput("evict_hit_count", hit_count_o, 32'd4);
    checkOutput("evict_miss_count2", miss_count_o, 32'd2);
    applyStimulus(32'h0000_030C, 32'h0, 4'h0, 1'b1);
    #1 checkOutput("stalled_word_miss", {31'd0, miss_o}, 32'd0);
    nextCycle();
    checkOutput("stalled_word_data", read_data_o, 32'hB000_0003);
    checkOutput("stalled_hit_count", hit_count_o, 32'd5);

    $display("[TB] reset mid-fill");
    applyStimulus(32'h0000_0500, 32'h0, 4'h0, 1'b1);
    #1 checkOutput("rfill_miss", {31'd0, miss_o}, 32'd1);
    nextCycle();
    checkOutput("rfill_miss_count", miss_count_o, 32'd3);
    runFill(32'h0000_0500, 32'hC000_0000, -1, 4);
    rst_i = 1'b1;
    nextCycle();
    rst_i = 1'b0;
    checkOutput("rfill_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rfill_hit_count", hit_count_o, 32'd0);
    checkOutput("rfill_miss_count0", miss_count_o, 32'd0);
    checkOutput("rfill_read_data", read_data_o, 32'h0);
    checkOutput("rfill_miss_after", {31'd0, miss_o}, 32'd1);
    nextCycle();
    checkOutput("refill_miss_count", miss_count_o, 32'd1);
    runFill(32'h0000_0500, 32'hC000_0000, -1, 8);
    checkOutput("refill_hit_miss", {31'd0, miss_o}, 32'd0);
    nextCycle();
    checkOutput("refill_read_data", read_data_o, 32'hC000_0000);
    checkOutput("refill_hit_count", hit_count_o, 32'd1);

    $display("[TB] idle cycles");
    applyStimulus(32'h0000_0500, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("idle_miss", {31'd0, miss_o}, 32'd0);
      checkOutput("idle_mem_req", {31'd0, mem_req_o}, 32'd0);
      checkOutput("idle_hit_count", hit_count_o, 32'd1);
      checkOutput("idle_miss_count", miss_count_o, 32'd1);
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
